// File: rtl/serial_to_parallel.sv
// serial_to_parallel: LSB-first serial-in, parallel-out deserializer with a one-word holding register.
// Optional feature macro SER_PARITY_EN: each frame carries a trailing even-parity bit reported on out_perr.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   clr                         synchronous clear of any partial frame (held word untouched)
//   s_valid, s_bit, s_ready     serial bit input handshake
//   out_valid, out_ready        word output handshake
//   out_data, out_perr          assembled word (first bit in bit 0) and its parity error flag
module serial_to_parallel #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             s_valid,
    input  logic             s_bit,
    output logic             s_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_perr
);
    localparam int CW = $clog2(WIDTH + 1);
`ifdef SER_PARITY_EN
    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PAR} state_t;
    logic perr_q, perr_d;
`else
    typedef enum logic {S_IDLE, S_DATA} state_t;
`endif
    state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] sh_q, sh_d, data_q, data_d, shifted;
    logic valid_q, valid_d, pending, accept, complete;
    assign shifted = {s_bit, sh_q[WIDTH-1:1]};
    // pending: the next accepted bit closes the frame and needs the holding register
`ifdef SER_PARITY_EN
    assign pending = state_q == S_PAR;
    assign out_perr = perr_q;
`else
    assign pending = cnt_q == CW'(WIDTH - 1);
    assign out_perr = 1'b0;
`endif
    assign s_ready = !(pending && valid_q && !out_ready);
    assign accept = s_valid && s_ready && !clr;
    assign complete = accept && pending;
    assign out_valid = valid_q;
    assign out_data = data_q;
    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        sh_d = sh_q;
        data_d = data_q;
        valid_d = valid_q && !out_ready;
`ifdef SER_PARITY_EN
        perr_d = perr_q;
`endif
        if (clr) begin
            state_d = S_IDLE;
            cnt_d = '0;
            sh_d = '0;
        end else if (complete) begin
            state_d = S_IDLE;
            cnt_d = '0;
            valid_d = 1'b1;
`ifdef SER_PARITY_EN
            data_d = sh_q;
            perr_d = ^sh_q ^ s_bit;
`else
            data_d = shifted;
            sh_d = shifted;
`endif
        end else if (accept) begin
            sh_d = shifted;
            cnt_d = cnt_q + 1'b1;
`ifdef SER_PARITY_EN
            state_d = (cnt_q == CW'(WIDTH - 1)) ? S_PAR : S_DATA;
`else
            state_d = S_DATA;
`endif
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q <= '0;
            sh_q <= '0;
            data_q <= '0;
            valid_q <= 1'b0;
`ifdef SER_PARITY_EN
            perr_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            sh_q <= sh_d;
            data_q <= data_d;
            valid_q <= valid_d;
`ifdef SER_PARITY_EN
            perr_q <= perr_d;
`endif
        end
    end
endmodule

// File: tb/tb_serial_to_parallel.sv
// tb_serial_to_parallel: directed self-checking bench for serial_to_parallel.
module tb_serial_to_parallel;
    localparam int W = 8;
`ifdef SER_PARITY_EN
    localparam int FL = W + 1;
`else
    localparam int FL = W;
`endif
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clr = 1'b0;
    logic s_valid = 1'b0;
    logic s_bit = 1'b0;
    logic out_ready = 1'b0;
    logic s_ready, out_valid, out_perr;
    logic [W-1:0] out_data;
    int checks = 0;
    int failures = 0;

    serial_to_parallel #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .s_valid(s_valid), .s_bit(s_bit),
        .s_ready(s_ready), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_perr(out_perr)
    );

    always #5 clk = ~clk;

    function automatic logic fbit(input logic [W-1:0] w, input int i);
        return (i < W) ? w[i] : ^w;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        s_valid = 1'b1;
        s_bit = b;
        step();
        s_valid = 1'b0;
    endtask

    task automatic send_bits(input logic [W-1:0] w, input int n);
        for (int i = 0; i < n; i++) send_bit(fbit(w, i));
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL reset_s_ready got=%b exp=1", s_ready); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (out_data !== '0) begin failures++; $display("FAIL reset_out_data got=%h exp=00", out_data); end
        checks++; if (out_perr !== 1'b0) begin failures++; $display("FAIL reset_out_perr got=%b exp=0", out_perr); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_basic();
        logic [W-1:0] rev;
        out_ready = 1'b1;
        send_bits(8'h58, FL - 1);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL basic_early_valid got=%b exp=0", out_valid); end
        send_bits(8'h58 >> 0, 0);
        send_bit(fbit(8'h58, FL - 1));
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL basic_valid got=%b exp=1", out_valid); end
        checks++; if (out_data !== 8'b01011000) begin failures++; $display("FAIL basic_data got=%h exp=58", out_data); end
        checks++; if (out_perr !== 1'b0) begin failures++; $display("FAIL basic_perr got=%b exp=0", out_perr); end
        for (int i = 0; i < W; i++) rev[i] = out_data[W-1-i];
        checks++; if (rev !== 8'b00011010) begin failures++; $display("FAIL basic_reversed got=%b exp=00011010", rev); end
        step();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL basic_one_cycle got=%b exp=0", out_valid); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        send_bits(8'hAA, FL);
        checks++; if (out_valid !== 1'b1 || out_data !== 8'hAA) begin failures++; $display("FAIL bp_first got=%b/%h exp=1/aa", out_valid, out_data); end
        send_bits(8'h3C, FL - 1);
        s_valid = 1'b1;
        s_bit = fbit(8'h3C, FL - 1);
        #1;
        checks++; if (s_ready !== 1'b0) begin failures++; $display("FAIL bp_s_ready_low got=%b exp=0", s_ready); end
        step();
        checks++; if (out_data !== 8'hAA || out_valid !== 1'b1) begin failures++; $display("FAIL bp_hold got=%b/%h exp=1/aa", out_valid, out_data); end
        checks++; if (s_ready !== 1'b0) begin failures++; $display("FAIL bp_still_stalled got=%b exp=0", s_ready); end
        out_ready = 1'b1;
        #1;
        checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL bp_s_ready_release got=%b exp=1", s_ready); end
        step();
        s_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_data !== 8'h3C) begin failures++; $display("FAIL bp_second got=%b/%h exp=1/3c", out_valid, out_data); end
        step();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_drain got=%b exp=0", out_valid); end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] w;
        out_ready = 1'b1;
        s_valid = 1'b1;
        for (int k = 0; k < 2 * FL; k++) begin
            w = (k < FL) ? 8'hF0 : 8'h81;
            s_bit = fbit(w, k % FL);
            #1;
            checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL b2b_s_ready k=%0d got=%b exp=1", k, s_ready); end
            step();
            if (k % FL == FL - 1) begin
                checks++; if (out_valid !== 1'b1 || out_data !== w) begin failures++; $display("FAIL b2b_word k=%0d got=%b/%h exp=1/%h", k, out_valid, out_data, w); end
            end else begin
                checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_idle k=%0d got=%b exp=0", k, out_valid); end
            end
        end
        s_valid = 1'b0;
        step();
    endtask

    task automatic test_clr();
        out_ready = 1'b0;
        send_bits(8'h5A, FL);
        send_bits(8'hFF, 5);
        clr = 1'b1;
        s_valid = 1'b1;
        s_bit = 1'b1;
        step();
        clr = 1'b0;
        s_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_data !== 8'h5A) begin failures++; $display("FAIL clr_keeps_word got=%b/%h exp=1/5a", out_valid, out_data); end
        out_ready = 1'b1;
        step();
        send_bits(8'h01, FL - 1);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL clr_early_valid got=%b exp=0", out_valid); end
        send_bit(fbit(8'h01, FL - 1));
        checks++; if (out_valid !== 1'b1 || out_data !== 8'h01) begin failures++; $display("FAIL clr_frame got=%b/%h exp=1/01", out_valid, out_data); end
        step();
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        send_bits(8'h77, FL);
        send_bits(8'h12, FL - 1);
        checks++; if (s_ready !== 1'b0) begin failures++; $display("FAIL ar_pre_s_ready got=%b exp=0", s_ready); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL ar_out_valid got=%b exp=0", out_valid); end
        checks++; if (out_data !== '0) begin failures++; $display("FAIL ar_out_data got=%h exp=00", out_data); end
        checks++; if (out_perr !== 1'b0) begin failures++; $display("FAIL ar_out_perr got=%b exp=0", out_perr); end
        checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL ar_s_ready got=%b exp=1", s_ready); end
        step();
        rst_n = 1'b1;
        out_ready = 1'b1;
        step();
        send_bits(8'hC3, FL);
        checks++; if (out_valid !== 1'b1 || out_data !== 8'hC3) begin failures++; $display("FAIL ar_next_frame got=%b/%h exp=1/c3", out_valid, out_data); end
        step();
    endtask

`ifdef SER_PARITY_EN
    task automatic test_parity();
        out_ready = 1'b1;
        send_bits(8'h03, W);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL par_early1 got=%b exp=0", out_valid); end
        send_bit(1'b0);
        checks++; if (out_valid !== 1'b1 || out_data !== 8'h03 || out_perr !== 1'b0) begin failures++; $display("FAIL par_word1 got=%b/%h/%b exp=1/03/0", out_valid, out_data, out_perr); end
        send_bits(8'h07, W);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL par_early2 got=%b exp=0", out_valid); end
        send_bit(1'b0);
        checks++; if (out_valid !== 1'b1 || out_data !== 8'h07 || out_perr !== 1'b1) begin failures++; $display("FAIL par_word2 got=%b/%h/%b exp=1/07/1", out_valid, out_data, out_perr); end
        step();
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_back_to_back();
        test_clr();
        test_async_reset();
`ifdef SER_PARITY_EN
        test_parity();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
